uart_alu_bridge_dec: RTL and testbench

//  Sits between the UART rx/tx FIFOs and the ALU. Parses decimal ASCII

---
 rtl/uart_alu_pkg.sv | 42 ++++
 rtl/bin2bcd_seq.sv | 57 +++++
 rtl/uart_alu_bridge_dec.sv | 180 ++++++++++++++++++
 tb/tb_uart_alu_bridge_dec.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_pkg.sv
// Shared constants for the UART/ALU decimal bridge: ASCII codes, ALU opcodes,
// parser state encoding and the opcode-digit decoder.
package uart_alu_pkg;

  localparam logic [7:0] ASCII_CR = 8'd13;
  localparam logic [7:0] ASCII_LF = 8'd10;
  localparam logic [7:0] ASCII_0  = 8'd48;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  typedef enum logic [2:0] {
    S_A     = 3'd0,
    S_B     = 3'd1,
    S_OP    = 3'd2,
    S_LATCH = 3'd3,
    S_CONV  = 3'd4,
    S_TX    = 3'd5
  } state_t;

  // Returns {bad_opcode, opcode}; an unknown digit falls back to ADD.
  function automatic logic [6:0] decode_op(input logic [7:0] b);
    case (b)
      8'h31:   decode_op = {1'b0, OP_ADD};
      8'h32:   decode_op = {1'b0, OP_SUB};
      8'h33:   decode_op = {1'b0, OP_AND};
      8'h34:   decode_op = {1'b0, OP_OR};
      8'h35:   decode_op = {1'b0, OP_XOR};
      8'h36:   decode_op = {1'b0, OP_SRA};
      8'h37:   decode_op = {1'b0, OP_SRL};
      8'h38:   decode_op = {1'b0, OP_NOR};
      default: decode_op = {1'b1, OP_ADD};
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per cycle;
// done pulses N cycles after start and bcd_o holds until the next start.
module bin2bcd_seq
  import uart_alu_pkg::*;
#(
  parameter int N      = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [N-1:0]          bin_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  done_o
);

  localparam int W  = 4*DIGITS + N;
  localparam int CW = $clog2(N+1);

  logic [W-1:0]  sr_q;
  logic [W-1:0]  sr_adj;
  logic [CW-1:0] cnt_q;
  logic          done_q;

  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_q[N+4*i +: 4] >= 4'd5)
        sr_adj[N+4*i +: 4] = sr_q[N+4*i +: 4] + 4'd3;
    end
  end

  // Rotate rather than shift: the recycled top bit lands in the spent binary
  // field and cannot reach the BCD field within N steps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        sr_q  <= {{(4*DIGITS){1'b0}}, bin_i};
        cnt_q <= CW'(N);
      end else if (cnt_q != '0) begin
        sr_q  <= {sr_adj[W-2:0], sr_adj[W-1]};
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1))
          done_q <= 1'b1;
      end
    end
  end

  assign bcd_o  = sr_q[W-1:N];
  assign done_o = done_q;

endmodule

// File: rtl/uart_alu_bridge_dec.sv
// Bridge between UART FIFOs and the ALU: parses decimal operands and an
// opcode digit from rx, returns the ALU result as decimal ASCII plus CR LF.
//
// state   | meaning
// S_A     | accumulate operand A digits until CR
// S_B     | accumulate operand B digits until CR
// S_OP    | pop opcode digit, drive dato_Op, raise busy
// S_LATCH | ALU settles, capture result, start converter
// S_CONV  | wait for BCD conversion
// S_TX    | push digits (leading zeros skipped), CR, LF
module uart_alu_bridge_dec
  import uart_alu_pkg::*;
#(
  parameter int N      = 8,
  parameter int DIGITS = 3,
  parameter int OPW    = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rx_empty_i,
  input  logic [7:0]     rx_data_i,
  output logic           rd_uart_o,
  input  logic           tx_full_i,
  output logic [7:0]     tx_data_o,
  output logic           wr_uart_o,
  input  logic [N-1:0]   alu_result_i,
  output logic [N-1:0]   dato_A_o,
  output logic [N-1:0]   dato_B_o,
  output logic [OPW-1:0] dato_Op_o,
  output logic           busy_o,
  output logic           err_o
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t               state_q;
  logic [N-1:0]         acc_q, dato_a_q, dato_b_q, res_q;
  logic [OPW-1:0]       dato_op_q;
  logic [7:0]           tx_data_q;
  logic                 rd_q, wr_q, busy_q, err_q, start_q;
  logic                 a_seen_q, nz_q;
  logic [IW-1:0]        idx_q;
  logic [1:0]           tx_ph_q;

  logic [N+3:0]         acc_d;
  logic                 acc_ovf, is_digit, rx_take;
  logic [6:0]           op_dec;
  logic [3:0]           cur_digit;
  logic [4*DIGITS-1:0]  bcd;
  logic                 bcd_done;

  always_comb begin
    is_digit  = (rx_data_i >= ASCII_0) && (rx_data_i <= ASCII_0 + 8'd9);
    acc_d     = ({4'b0000, acc_q} * (N+4)'(10)) + (N+4)'(rx_data_i[3:0]);
    acc_ovf   = |acc_d[N+3:N];
    op_dec    = decode_op(rx_data_i);
    cur_digit = bcd[{idx_q, 2'b00} +: 4];
    // The FIFO head still shows the popped byte while rd_uart is high.
    rx_take   = !rx_empty_i && !rd_q;
  end

  bin2bcd_seq #(.N(N), .DIGITS(DIGITS)) u_bcd (
    .clk     (clk),
    .reset   (reset),
    .start_i (start_q),
    .bin_i   (res_q),
    .bcd_o   (bcd),
    .done_o  (bcd_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_A;
      acc_q     <= '0;
      dato_a_q  <= '0;
      dato_b_q  <= '0;
      res_q     <= '0;
      dato_op_q <= OPW'(OP_ADD);
      tx_data_q <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      a_seen_q  <= 1'b0;
      nz_q      <= 1'b0;
      idx_q     <= '0;
      tx_ph_q   <= '0;
    end else begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      start_q <= 1'b0;
      case (state_q)
        S_A, S_B: begin
          if (rx_take) begin
            rd_q <= 1'b1;
            if (is_digit) begin
              acc_q <= acc_d[N-1:0];
              if (state_q == S_A && !a_seen_q) err_q <= acc_ovf;
              else                             err_q <= err_q | acc_ovf;
              if (state_q == S_A) a_seen_q <= 1'b1;
            end else if (rx_data_i == ASCII_CR) begin
              acc_q <= '0;
              if (state_q == S_A) begin
                dato_a_q <= acc_q;
                state_q  <= S_B;
              end else begin
                dato_b_q <= acc_q;
                state_q  <= S_OP;
              end
            end
          end
        end
        S_OP: begin
          if (rx_take) begin
            rd_q      <= 1'b1;
            dato_op_q <= OPW'(op_dec[5:0]);
            err_q     <= err_q | op_dec[6];
            busy_q    <= 1'b1;
            state_q   <= S_LATCH;
          end
        end
        S_LATCH: begin
          res_q   <= alu_result_i;
          start_q <= 1'b1;
          state_q <= S_CONV;
        end
        S_CONV: begin
          if (bcd_done) begin
            idx_q   <= IW'(DIGITS-1);
            nz_q    <= 1'b0;
            tx_ph_q <= 2'd0;
            state_q <= S_TX;
          end
        end
        S_TX: begin
          if (!tx_full_i) begin
            case (tx_ph_q)
              2'd0: begin
                if (cur_digit == 4'd0 && !nz_q && idx_q != '0) begin
                  idx_q <= idx_q - IW'(1);
                end else begin
                  tx_data_q <= ASCII_0 + {4'b0000, cur_digit};
                  wr_q      <= 1'b1;
                  nz_q      <= 1'b1;
                  if (idx_q == '0) tx_ph_q <= 2'd1;
                  else             idx_q   <= idx_q - IW'(1);
                end
              end
              2'd1: begin
                tx_data_q <= ASCII_CR;
                wr_q      <= 1'b1;
                tx_ph_q   <= 2'd2;
              end
              default: begin
                tx_data_q <= ASCII_LF;
                wr_q      <= 1'b1;
                busy_q    <= 1'b0;
                acc_q     <= '0;
                a_seen_q  <= 1'b0;
                state_q   <= S_A;
              end
            endcase
          end
        end
        default: state_q <= S_A;
      endcase
    end
  end

  assign rd_uart_o = rd_q;
  assign wr_uart_o = wr_q;
  assign tx_data_o = tx_data_q;
  assign dato_A_o  = dato_a_q;
  assign dato_B_o  = dato_b_q;
  assign dato_Op_o = dato_op_q;
  assign busy_o    = busy_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_uart_alu_bridge_dec.sv
// Bench for uart_alu_bridge_dec: FWFT rx FIFO and tx sink models, table of
// complete transactions, then tx back-pressure and mid-operand reset sequences.
module tb_uart_alu_bridge_dec;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rd_uart;
  logic       tx_full = 1'b0;
  logic [7:0] tx_data;
  logic       wr_uart;
  logic [7:0] alu_result = 8'h00;
  logic [7:0] dato_A, dato_B;
  logic [5:0] dato_Op;
  logic       busy, err;

  always #5 clk = ~clk;

  uart_alu_bridge_dec #(.N(8), .DIGITS(3), .OPW(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_empty_i   (rx_empty),
    .rx_data_i    (rx_data),
    .rd_uart_o    (rd_uart),
    .tx_full_i    (tx_full),
    .tx_data_o    (tx_data),
    .wr_uart_o    (wr_uart),
    .alu_result_i (alu_result),
    .dato_A_o     (dato_A),
    .dato_B_o     (dato_B),
    .dato_Op_o    (dato_Op),
    .busy_o       (busy),
    .err_o        (err)
  );

  typedef struct {
    logic [95:0] rx;
    int          rx_len;
    logic [7:0]  alu;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [5:0]  op;
    logic        e;
    logic [63:0] tx;
    int          tx_len;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  int         checks = 0;
  int         passes = 0;
  int         stall_viol = 0;
  logic       full_at_edge = 1'b0;

  always @(posedge clk) full_at_edge <= tx_full;

  // rx FIFO (first-word-fall-through) and tx sink, both updated mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (rd_uart && rxq.size() > 0) void'(rxq.pop_front());
      if (wr_uart) begin
        txq.push_back(tx_data);
        if (full_at_edge) stall_viol++;
      end
    end
    rx_empty = (rxq.size() == 0);
    rx_data  = (rxq.size() > 0) ? rxq[0] : 8'h00;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  function automatic vec_t mk(input logic [95:0] rx, input int rl, input logic [7:0] alu,
                              input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                              input logic e, input logic [63:0] tx, input int tl);
    vec_t v;
    v.rx = rx; v.rx_len = rl; v.alu = alu; v.a = a; v.b = b;
    v.op = op; v.e = e; v.tx = tx; v.tx_len = tl;
    return v;
  endfunction

  function automatic logic [63:0] tx_packed();
    logic [63:0] got = '0;
    foreach (txq[j]) got = {got[55:0], txq[j]};
    return got;
  endfunction

  task automatic push_bytes(input logic [95:0] s, input int len);
    for (int i = 0; i < len; i++) rxq.push_back(s[8*(len-1-i) +: 8]);
  endtask

  task automatic wait_txn(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (busy) begin ok = 1'b1; break; end
    end
    chk({name, " busy rise"}, 64'(ok), 64'd1);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    chk({name, " busy fall"}, 64'(ok), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " dato_A"},  64'(dato_A),  64'd0);
    chk({tag, " dato_B"},  64'(dato_B),  64'd0);
    chk({tag, " dato_Op"}, 64'(dato_Op), 64'(6'b100000));
    chk({tag, " tx_data"}, 64'(tx_data), 64'd0);
    chk({tag, " rd_uart"}, 64'(rd_uart), 64'd0);
    chk({tag, " wr_uart"}, 64'(wr_uart), 64'd0);
    chk({tag, " busy"},    64'(busy),    64'd0);
    chk({tag, " err"},     64'(err),     64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [7:0] held;

    vecs[0] = mk("12\01534\0151",  7, 8'd46,  8'd12,  8'd34, 6'b100000, 1'b0, "46\015\012",  4);
    vecs[1] = mk("255\0150\0152",  7, 8'd0,   8'd255, 8'd0,  6'b100010, 1'b0, "0\015\012",   3);
    vecs[2] = mk("300\0150\0153",  7, 8'd7,   8'd44,  8'd0,  6'b100100, 1'b1, "7\015\012",   3);
    vecs[3] = mk("1\0152\0159",    5, 8'd3,   8'd1,   8'd2,  6'b100000, 1'b1, "3\015\012",   3);
    vecs[4] = mk("5\015\0156",     4, 8'd200, 8'd5,   8'd0,  6'b000011, 1'b0, "200\015\012", 5);
    vecs[5] = mk("x7\0158\0158",   6, 8'd255, 8'd7,   8'd8,  6'b100111, 1'b0, "255\015\012", 5);

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      alu_result = vecs[k].alu;
      txq.delete();
      push_bytes(vecs[k].rx, vecs[k].rx_len);
      wait_txn($sformatf("v%0d", k));
      chk($sformatf("v%0d dato_A", k),  64'(dato_A),  64'(vecs[k].a));
      chk($sformatf("v%0d dato_B", k),  64'(dato_B),  64'(vecs[k].b));
      chk($sformatf("v%0d dato_Op", k), 64'(dato_Op), 64'(vecs[k].op));
      chk($sformatf("v%0d err", k),     64'(err),     64'(vecs[k].e));
      chk($sformatf("v%0d tx_len", k),  64'(txq.size()), 64'(vecs[k].tx_len));
      chk($sformatf("v%0d tx_bytes", k), tx_packed(), vecs[k].tx);
    end

    // tx back-pressure: hold tx_full for 5 cycles right after "1" is pushed
    alu_result = 8'd123;
    txq.delete();
    stall_viol = 0;
    push_bytes("9\0159\0151", 5);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (wr_uart && tx_data == 8'h31) begin ok = 1'b1; break; end
    end
    chk("stall first digit seen", 64'(ok), 64'd1);
    tx_full = 1'b1;
    repeat (5) @(negedge clk);
    held = tx_data;
    tx_full = 1'b0;
    chk("stall tx_data held", 64'(held), 64'h31);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    chk("stall busy fall", 64'(ok), 64'd1);
    repeat (3) @(negedge clk);
    chk("stall no push while full", 64'(stall_viol), 64'd0);
    chk("stall tx_len", 64'(txq.size()), 64'd5);
    chk("stall tx_bytes", tx_packed(), 64'h31_32_33_0D_0A);

    // reset in the middle of operand "25", after the "2" is consumed
    alu_result = 8'd0;
    txq.delete();
    push_bytes("25", 2);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rxq.delete();
    #1;
    chk_reset_vals("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    push_bytes("7\015", 2);
    repeat (10) @(negedge clk);
    chk("postreset dato_A", 64'(dato_A), 64'd7);
    chk("postreset err",    64'(err),    64'd0);
    chk("postreset no tx",  64'(txq.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
